// File: rtl/sm_display_pkg.sv
// sm_display_pkg: shared constants and helpers for the multiplexed hex display.
//   SEG_HEX    - active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F
//   SEG_OFF    - active-high pattern with every segment off
//   hex_to_seg - nibble to active-high segment pattern
package sm_display_pkg;

   localparam logic [6:0] SEG_OFF = 7'h00;

   localparam logic [6:0] SEG_HEX [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      return SEG_HEX[nib];
   endfunction

endpackage

// File: rtl/sm_display_scan.sv
// sm_display_scan: slot counter, digit index, PWM window and frame boundary.
//   clock, reset  - sole clock; synchronous active-high reset
//   brightness    - live PWM level, 0 = dimmest lit, all-ones = always lit
//   idx           - digit currently being scanned
//   pwm_on        - current cycle lies inside the PWM lit window
//   frame_end     - last cycle of the last digit slot of a frame
module sm_display_scan #(
   parameter int unsigned DIGITS        = 8,
   parameter int unsigned PRESCALE_LOG2 = 10,
   parameter int unsigned DIM_BITS      = 3,
   localparam int unsigned IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [DIM_BITS-1:0] brightness,
   output logic [IDX_W-1:0]    idx,
   output logic                pwm_on,
   output logic                frame_end
);

   logic [PRESCALE_LOG2-1:0] cnt_q;
   logic [IDX_W-1:0]         idx_q;
   logic                     slot_end;

   always_comb begin
      slot_end  = &cnt_q;
      frame_end = slot_end && (idx_q == IDX_W'(DIGITS - 1));
      // Top bits of the slot counter sweep 0..2^DIM_BITS-1 once per slot.
      pwm_on    = cnt_q[PRESCALE_LOG2-1 -: DIM_BITS] <= brightness;
      idx       = idx_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_q + PRESCALE_LOG2'(1);
         if (slot_end) begin
            // With a single digit every slot end is also a frame end, so idx stays 0.
            idx_q <= frame_end ? '0 : idx_q + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/sm_hex_display_mux.sv
// sm_hex_display_mux: multiplexed hex display driver with tear-free updates.
//   clock, reset     - sole clock; synchronous active-high reset
//   number, dots     - hex nibbles (digit 0 rightmost) and decimal points to show
//   upd_valid/ready  - capture handshake into the pending buffer
//   digit_en         - live per-digit enable mask
//   blank_lz         - live leading-zero blanking enable
//   brightness       - live PWM level
//   seven_segments   - {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   dot              - decimal point, polarity set by SEG_ACTIVE_LOW
//   anodes           - one-hot digit select, polarity set by AN_ACTIVE_LOW
//   frame_start      - one-cycle pulse aligned with the first output of digit 0
module sm_hex_display_mux
   import sm_display_pkg::*;
#(
   parameter int unsigned DIGITS         = 8,
   parameter int unsigned PRESCALE_LOG2  = 10,
   parameter int unsigned DIM_BITS       = 3,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   number,
   input  logic [DIGITS-1:0]     dots,
   input  logic                  upd_valid,
   output logic                  upd_ready,
   input  logic [DIGITS-1:0]     digit_en,
   input  logic                  blank_lz,
   input  logic [DIM_BITS-1:0]   brightness,
   output logic [6:0]            seven_segments,
   output logic                  dot,
   output logic [DIGITS-1:0]     anodes,
   output logic                  frame_start
);

   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [IDX_W-1:0]    idx;
   logic                pwm_on;
   logic                frame_end;

   logic [4*DIGITS-1:0] p_num_q, p_num_d, d_num_q, d_num_d;
   logic [DIGITS-1:0]   p_dots_q, p_dots_d, d_dots_q, d_dots_d;
   logic                pend_q, pend_d;
   logic                ready_q;
   logic                fb_q;
   logic                fs_q;
   logic [6:0]          seg_q, seg_d;
   logic                dot_q, dot_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [DIGITS-1:0]   blank;
   logic                zero_run;
   logic                lit;
   logic [3:0]          nib;

   sm_display_scan #(
      .DIGITS        (DIGITS),
      .PRESCALE_LOG2 (PRESCALE_LOG2),
      .DIM_BITS      (DIM_BITS)
   ) u_scan (
      .clock      (clock),
      .reset      (reset),
      .brightness (brightness),
      .idx        (idx),
      .pwm_on     (pwm_on),
      .frame_end  (frame_end)
   );

   // Buffer and handshake next state. A transfer needs pend clear, a commit needs it
   // set, so the two can never fire together.
   always_comb begin
      pend_d   = pend_q;
      p_num_d  = p_num_q;
      p_dots_d = p_dots_q;
      d_num_d  = d_num_q;
      d_dots_d = d_dots_q;
      if (frame_end && pend_q) begin
         d_num_d  = p_num_q;
         d_dots_d = p_dots_q;
         pend_d   = 1'b0;
      end else if (upd_valid && ready_q) begin
         p_num_d  = number;
         p_dots_d = dots;
         pend_d   = 1'b1;
      end
   end

   // Digit i > 0 is blank when it and every more significant nibble are zero.
   always_comb begin
      zero_run = 1'b1;
      blank    = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (d_num_q[4*i +: 4] == 4'h0);
         if (i > 0) begin
            blank[i] = zero_run && blank_lz;
         end
      end
   end

   // Active-high output values for the digit being scanned this cycle.
   always_comb begin
      nib   = d_num_q[4*idx +: 4];
      lit   = digit_en[idx] && !blank[idx] && pwm_on;
      seg_d = lit ? hex_to_seg(nib) : SEG_OFF;
      dot_d = lit && d_dots_q[idx];
      an_d  = '0;
      if (lit) begin
         an_d[idx] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         p_num_q  <= '0;
         p_dots_q <= '0;
         pend_q   <= 1'b0;
         d_num_q  <= '0;
         d_dots_q <= '0;
         ready_q  <= 1'b1;
         fb_q     <= 1'b0;
         fs_q     <= 1'b0;
         seg_q    <= {7{SEG_ACTIVE_LOW}};
         dot_q    <= SEG_ACTIVE_LOW;
         an_q     <= {DIGITS{AN_ACTIVE_LOW}};
      end else begin
         p_num_q  <= p_num_d;
         p_dots_q <= p_dots_d;
         pend_q   <= pend_d;
         d_num_q  <= d_num_d;
         d_dots_q <= d_dots_d;
         ready_q  <= ~pend_d;
         // fb_q marks the first cycle of a frame; registering it once more lines the
         // pulse up with digit 0's first registered output.
         fb_q     <= frame_end;
         fs_q     <= fb_q;
         seg_q    <= seg_d ^ {7{SEG_ACTIVE_LOW}};
         dot_q    <= dot_d ^ SEG_ACTIVE_LOW;
         an_q     <= an_d ^ {DIGITS{AN_ACTIVE_LOW}};
      end
   end

   assign upd_ready      = ready_q;
   assign frame_start    = fs_q;
   assign seven_segments = seg_q;
   assign dot            = dot_q;
   assign anodes         = an_q;

endmodule

// File: tb/tb_sm_hex_display_mux.sv
// tb_sm_hex_display_mux: directed bench for sm_hex_display_mux (4 digits, 4-cycle
// slots, 2-bit brightness, active-low outputs). A time-based model predicts every
// registered output each cycle; directed checks pin the model with literal values.
module tb_sm_hex_display_mux;

   logic        clock;
   logic        reset;
   logic [15:0] number;
   logic [3:0]  dots;
   logic        upd_valid;
   logic        upd_ready;
   logic [3:0]  digit_en;
   logic        blank_lz;
   logic [1:0]  brightness;
   logic [6:0]  seven_segments;
   logic        dot;
   logic [3:0]  anodes;
   logic        frame_start;

   int vectors = 0;
   int miscompares = 0;

   sm_hex_display_mux #(
      .DIGITS         (4),
      .PRESCALE_LOG2  (2),
      .DIM_BITS       (2),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .number         (number),
      .dots           (dots),
      .upd_valid      (upd_valid),
      .upd_ready      (upd_ready),
      .digit_en       (digit_en),
      .blank_lz       (blank_lz),
      .brightness     (brightness),
      .seven_segments (seven_segments),
      .dot            (dot),
      .anodes         (anodes),
      .frame_start    (frame_start)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam logic [6:0] SEG_TAB [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   int unsigned t;           // cycles since reset release
   logic [15:0] m_pnum, m_dnum;
   logic [3:0]  m_pdots, m_ddots;
   logic        m_pend, m_ready;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dot, e_fs;
   bit          mvalid = 0;

   always @(posedge clock) begin
      int   slot, dig;
      bit   lit, blanked;
      logic [3:0] nib;
      if (reset) begin
         t = 0; m_pend = 0; m_ready = 1;
         m_pnum = 0; m_pdots = 0; m_dnum = 0; m_ddots = 0;
         e_an = 4'hF; e_seg = 7'h7F; e_dot = 1; e_fs = 0;
         mvalid = 1;
      end else if (mvalid) begin
         // Outputs after this edge show the cycle t that just ended.
         slot    = t % 4;
         dig     = (t / 4) % 4;
         nib     = m_dnum[4*dig +: 4];
         blanked = blank_lz && (dig > 0) && ((m_dnum >> (4 * dig)) == 16'h0);
         lit     = digit_en[dig] && !blanked && (slot <= int'(brightness));
         e_an = 4'hF; e_seg = 7'h7F; e_dot = 1;
         if (lit) begin
            e_an[dig] = 1'b0;
            e_seg     = ~SEG_TAB[nib];
            e_dot     = ~m_ddots[dig];
         end
         e_fs = (t != 0) && (t % 16 == 0);
         if ((t % 16 == 15) && m_pend) begin
            m_dnum = m_pnum; m_ddots = m_pdots; m_pend = 0;
         end else if (upd_valid && m_ready) begin
            m_pnum = number; m_pdots = dots; m_pend = 1;
         end
         m_ready = !m_pend;
         t++;
      end
   end

   always @(negedge clock) begin
      if (mvalid) begin
         check("anodes", anodes, e_an);
         check("seven_segments", seven_segments, e_seg);
         check("dot", dot, e_dot);
         check("upd_ready", upd_ready, m_ready);
         check("frame_start", frame_start, e_fs);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wait_fs();
      bit seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (frame_start) begin
            seen = 1;
            break;
         end
      end
      if (!seen) check("frame_start timeout", 0, 1);
   endtask

   task automatic send(input logic [15:0] n, input logic [3:0] d);
      bit ok = 0;
      for (int i = 0; i < 40; i++) begin
         if (upd_ready) begin
            ok = 1;
            break;
         end
         tick(1);
      end
      if (!ok) check("upd_ready timeout", 0, 1);
      number = n; dots = d; upd_valid = 1;
      tick(1);
      upd_valid = 0;
   endtask

   initial begin
      int k;
      int cnt [4];
      reset = 1; upd_valid = 0; number = 0; dots = 0;
      digit_en = 4'hF; blank_lz = 0; brightness = 2'd3;

      // Reset values
      tick(3);
      check("reset anodes", anodes, 4'hF);
      check("reset segments", seven_segments, 7'h7F);
      check("reset dot", dot, 1);
      check("reset upd_ready", upd_ready, 1);
      check("reset frame_start", frame_start, 0);
      reset = 0;

      // First frame_start: 16 full cycles after the first unreset cycle, i.e. it is
      // seen after the 17th edge that samples reset low.
      k = 0;
      for (int i = 1; i <= 40; i++) begin
         tick(1);
         if (frame_start) begin
            k = i;
            break;
         end
      end
      check("first frame_start edge", k, 17);
      check("first frame anodes", anodes, 4'hE);

      // Tear-free update
      tick(5);
      send(16'h12AF, 4'b0101);
      check("ready low after transfer", upd_ready, 0);
      check("old data still shown", seven_segments == 7'h40 || seven_segments == 7'h7F, 1);
      wait_fs();
      check("digit0 F anode", anodes, 4'hE);
      check("digit0 F segs", seven_segments, 7'h0E);
      check("digit0 dot", dot, 0);
      tick(12);
      check("digit3 1 anode", anodes, 4'h7);
      check("digit3 1 segs", seven_segments, 7'h79);
      check("digit3 dot", dot, 1);

      // Back-pressure: 1111 captured, 2222 held until the commit frees the buffer
      number = 16'h1111; dots = 0; upd_valid = 1;
      tick(1);
      number = 16'h2222;
      check("ready low while pending", upd_ready, 0);
      wait_fs();
      upd_valid = 0;
      check("first value shown", seven_segments, 7'h79);
      check("second value pending", upd_ready, 0);
      wait_fs();
      check("second value shown", seven_segments, 7'h24);

      // Leading-zero blanking
      blank_lz = 1;
      send(16'h0050, 4'b1100);
      wait_fs();
      check("lz digit0 anode", anodes, 4'hE);
      check("lz digit0 segs", seven_segments, 7'h40);
      tick(4);
      check("lz digit1 anode", anodes, 4'hD);
      check("lz digit1 segs", seven_segments, 7'h12);
      tick(4);
      check("lz digit2 dark", anodes, 4'hF);
      check("lz digit2 segs off", seven_segments, 7'h7F);
      check("lz digit2 dot off", dot, 1);

      // Number zero
      send(16'h0000, 4'b0000);
      wait_fs();
      check("zero digit0 segs", seven_segments, 7'h40);
      tick(4);
      check("zero digit1 dark", anodes, 4'hF);

      // Brightness
      blank_lz = 0; brightness = 2'd0;
      tick(1);
      cnt = '{0, 0, 0, 0};
      for (int c = 0; c < 16; c++) begin
         tick(1);
         for (int i = 0; i < 4; i++) if (!anodes[i]) cnt[i]++;
      end
      for (int i = 0; i < 4; i++) check($sformatf("dim0 anode%0d cycles", i), cnt[i], 1);
      brightness = 2'd3; digit_en = 4'b1011;
      tick(1);
      cnt = '{0, 0, 0, 0};
      for (int c = 0; c < 16; c++) begin
         tick(1);
         for (int i = 0; i < 4; i++) if (!anodes[i]) cnt[i]++;
      end
      check("full anode0 cycles", cnt[0], 4);
      check("full anode1 cycles", cnt[1], 4);
      check("disabled anode2 cycles", cnt[2], 0);
      check("full anode3 cycles", cnt[3], 4);

      // Reset mid-operation with a pending update
      digit_en = 4'hF;
      send(16'hABCD, 4'b0000);
      check("pending before reset", upd_ready, 0);
      tick(2);
      reset = 1;
      tick(1);
      check("mid reset anodes", anodes, 4'hF);
      check("mid reset ready", upd_ready, 1);
      reset = 0;
      tick(1);
      check("restart at digit0", anodes, 4'hE);
      check("restart display zero", seven_segments, 7'h40);
      wait_fs();
      check("pending discarded", seven_segments, 7'h40);

      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
